// File: rtl/rpn_stack_ctrl.sv
// rpn_stack_ctrl: RPN command sequencer driving push/pop strobes of a 32-bit LIFO and tracking its depth.
// Define RPN_MUL_EN to make opcode 7 an unsigned multiply; otherwise opcode 7 is rejected as illegal.
module rpn_stack_ctrl #(
  parameter int DEPTH  = 16,
  parameter int SETTLE = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CMD_VLD,
  output logic        CMD_RDY,
  input  logic [2:0]  CMD_OP,
  input  logic [31:0] CMD_DAT,
  output logic        STK_PUSH_STB,
  output logic [31:0] STK_PUSH_DAT,
  output logic        STK_POP_STB,
  input  logic [31:0] STK_POP_DAT,
  output logic        RES_VLD,
  output logic [31:0] RES_DAT,
  output logic [4:0]  DEPTH_CNT,
  output logic        ERR_STB,
  output logic [1:0]  ERR_CODE
);
  localparam int CW = $clog2(SETTLE + 1);
  typedef enum logic [2:0] {S_IDLE, S_POP_B, S_WAIT_A, S_POP_A, S_PUSH_R, S_SETTLE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] op_q;
  logic [31:0] a_q, b_q, r;
  logic accept, is_push, is_pop, illegal;
  logic [1:0] err;
  assign accept  = CMD_VLD && CMD_RDY;
  assign is_push = CMD_OP == 3'd0;
  assign is_pop  = CMD_OP == 3'd6;
`ifdef RPN_MUL_EN
  assign illegal = 1'b0;
`else
  assign illegal = CMD_OP == 3'd7;
`endif
  always_comb begin
    err = illegal ? 2'b11 :
          is_push ? (DEPTH_CNT == 5'(DEPTH) ? 2'b10 : 2'b00) :
          is_pop  ? (DEPTH_CNT == 5'd0 ? 2'b01 : 2'b00) :
                    (DEPTH_CNT < 5'd2 ? 2'b01 : 2'b00);
  end
  always_comb begin
    r = op_q == 3'd1 ? a_q + b_q :
        op_q == 3'd2 ? a_q - b_q :
        op_q == 3'd3 ? a_q & b_q :
        op_q == 3'd4 ? a_q | b_q :
`ifdef RPN_MUL_EN
        op_q == 3'd7 ? a_q * b_q :
`endif
                       a_q ^ b_q;
  end
  // Settle counter: state exits when cnt reaches 0, so a load of N gives N+1 cycles in that state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= S_IDLE;
      cnt          <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      CMD_RDY      <= 1'b0;
      STK_PUSH_STB <= 1'b0;
      STK_PUSH_DAT <= '0;
      STK_POP_STB  <= 1'b0;
      RES_VLD      <= 1'b0;
      RES_DAT      <= '0;
      DEPTH_CNT    <= '0;
      ERR_STB      <= 1'b0;
      ERR_CODE     <= '0;
    end else begin
      STK_PUSH_STB <= 1'b0;
      STK_POP_STB  <= 1'b0;
      RES_VLD      <= 1'b0;
      ERR_STB      <= 1'b0;
      case (state)
        S_IDLE: begin
          CMD_RDY <= 1'b1;
          if (accept && err != 2'b00) begin
            ERR_STB  <= 1'b1;
            ERR_CODE <= err;
          end else if (accept) begin
            CMD_RDY <= 1'b0;
            op_q    <= CMD_OP;
            if (is_push) begin
              STK_PUSH_STB <= 1'b1;
              STK_PUSH_DAT <= CMD_DAT;
              DEPTH_CNT    <= DEPTH_CNT + 5'd1;
              cnt          <= CW'(SETTLE);
              state        <= S_SETTLE;
            end else if (is_pop) begin
              STK_POP_STB <= 1'b1;
              RES_VLD     <= 1'b1;
              RES_DAT     <= STK_POP_DAT;
              DEPTH_CNT   <= DEPTH_CNT - 5'd1;
              cnt         <= CW'(SETTLE);
              state       <= S_SETTLE;
            end else begin
              STK_POP_STB <= 1'b1;
              b_q         <= STK_POP_DAT;
              DEPTH_CNT   <= DEPTH_CNT - 5'd1;
              state       <= S_POP_B;
            end
          end
        end
        S_POP_B: begin
          cnt   <= CW'(SETTLE - 1);
          state <= S_WAIT_A;
        end
        S_WAIT_A: begin
          if (cnt == '0) begin
            a_q         <= STK_POP_DAT;
            STK_POP_STB <= 1'b1;
            DEPTH_CNT   <= DEPTH_CNT - 5'd1;
            state       <= S_POP_A;
          end else cnt <= cnt - 1'b1;
        end
        S_POP_A: begin
          STK_PUSH_STB <= 1'b1;
          STK_PUSH_DAT <= r;
          RES_VLD      <= 1'b1;
          RES_DAT      <= r;
          DEPTH_CNT    <= DEPTH_CNT + 5'd1;
          state        <= S_PUSH_R;
        end
        S_PUSH_R: begin
          cnt   <= CW'(SETTLE - 1);
          state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            CMD_RDY <= 1'b1;
            state   <= S_IDLE;
          end else cnt <= cnt - 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/rpn_stack_ctrl.md
Name: rpn_stack_ctrl

Overview:
- Command sequencer that sits directly upstream of the 32-bit, 16-entry LIFO stack and is its only master.
- Accepts RPN commands (push immediate, pop, binary ALU ops) over a valid/ready handshake and translates each into single-cycle push/pop strobes.
- Tracks stack depth, because the stack itself has no full/empty protection.
- Reads operands from the stack's registered top-of-stack output and writes results back to the stack.

Parameters:
- DEPTH, 16: stack capacity in entries; also the overflow threshold for the depth counter.
- SETTLE, 2: cycles to wait after any push/pop strobe before the stack's top-of-stack output is valid (pointer update plus registered read).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-high.
- CMD_VLD  in  1  command valid.
- CMD_RDY  out  1  command ready; a command is accepted when CMD_VLD and CMD_RDY are both high.
- CMD_OP  in  3  opcode: 0 PUSH, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 POP, 7 MUL or illegal (see Optional Feature).
- CMD_DAT  in  32  immediate value for PUSH; ignored for other opcodes.
- STK_PUSH_STB  out  1  push strobe to the stack.
- STK_PUSH_DAT  out  32  push data to the stack.
- STK_POP_STB  out  1  pop strobe to the stack.
- STK_POP_DAT  in  32  stack top-of-stack read data.
- RES_VLD  out  1  single-cycle result pulse.
- RES_DAT  out  32  result value; held until the next RES_VLD.
- DEPTH_CNT  out  5  current stack occupancy, 0..DEPTH.
- ERR_STB  out  1  single-cycle error pulse.
- ERR_CODE  out  2  last error: 01 underflow, 10 overflow, 11 illegal opcode; held until the next error.

Behaviour:
- Reset: all outputs 0, DEPTH_CNT=0, state IDLE. CMD_RDY rises in the first cycle after RST deasserts. The stack shares RST, so depth stays consistent with the stack after a reset, including a reset in mid-command (in-flight command discarded).
- STK_PUSH_STB and STK_POP_STB: one-cycle pulses, never asserted in the same cycle. STK_PUSH_DAT is valid only while STK_PUSH_STB is high.
- States: IDLE, POP_B, WAIT_A, POP_A, PUSH_R, SETTLE.
- CMD_RDY=1 only in IDLE. On entry to IDLE the stack top is always settled, so STK_POP_DAT equals the top entry whenever DEPTH_CNT>0.
- Error checks happen at the accept edge. On an error: ERR_STB pulses the next cycle, ERR_CODE updates, the stack is untouched, and the FSM stays in IDLE (CMD_RDY stays 1).
- PUSH:
  - DEPTH_CNT==DEPTH gives overflow.
  - Otherwise the next cycle drives STK_PUSH_STB=1, STK_PUSH_DAT=CMD_DAT, and DEPTH_CNT+1; then SETTLE for SETTLE cycles; then IDLE.
  - No RES_VLD.
- POP:
  - DEPTH_CNT==0 gives underflow.
  - Otherwise RES_DAT<=STK_POP_DAT at the accept edge. Next cycle: STK_POP_STB=1, RES_VLD=1, DEPTH_CNT-1. Then SETTLE, then IDLE.
- Binary op (result = A op B, where B is the top entry and A is the entry below it):
  - DEPTH_CNT<2 gives underflow.
  - Latch B=STK_POP_DAT at the accept edge.
  - POP_B: STK_POP_STB=1 for 1 cycle.
  - WAIT_A: SETTLE cycles, then latch A=STK_POP_DAT.
  - POP_A: STK_POP_STB=1 for 1 cycle.
  - PUSH_R: STK_PUSH_STB=1, STK_PUSH_DAT=R, RES_VLD=1, RES_DAT=R.
  - Then SETTLE, then IDLE.
  - Net DEPTH_CNT change is -1.
  - With accept at cycle 0 and SETTLE=2: pops at cycles 1 and 4, push and RES_VLD at cycle 5, CMD_RDY high again at cycle 8.
- Arithmetic: 32-bit modulo. ADD and SUB wrap with no carry or borrow flag. SUB computes A-B.
- DEPTH_CNT never exceeds DEPTH and never goes below 0. The stack pointers are therefore never driven to wrap.

Optional Feature:
- Macro RPN_MUL_EN.
- Defined: opcode 7 = MUL, R = low 32 bits of A*B (unsigned), same sequence and latency as the other binary ops.
- Undefined: opcode 7 is illegal. ERR_CODE=11, ERR_STB pulses, no stack activity, no multiplier is synthesised.

Test Plan:
- PUSH 5, PUSH 3, SUB -> RES_VLD with RES_DAT=2; DEPTH_CNT=1; two pops then one push with STK_PUSH_DAT=2; CMD_RDY high 8 cycles after the SUB is accepted.
- PUSH 0xFFFFFFFF, PUSH 1, ADD -> RES_DAT=0; then POP -> RES_DAT=0, DEPTH_CNT=0.
- 16 PUSH commands then a 17th PUSH -> ERR_STB pulse, ERR_CODE=10, DEPTH_CNT stays 16, no STK_PUSH_STB.
- From reset: POP -> ERR_CODE=01; PUSH 7 then ADD -> ERR_CODE=01, DEPTH_CNT=1, then POP returns 7.
- Opcode 7 with A=6, B=7 -> RES_DAT=42 with RPN_MUL_EN defined; without it, ERR_CODE=11 and DEPTH_CNT unchanged.
- Assert RST during the WAIT_A state of an AND command -> all outputs 0, DEPTH_CNT=0; CMD_RDY rises in the first cycle after RST deasserts.
